// File: rtl/sonar_medidor.sv
// Ultrasonic range meter controller.
// Issues a trigger pulse, times the echo pulse, and converts the high time to
// centimetres as 3-digit BCD (floor of high cycles / CICLOS_POR_CM, saturating at 999).
// Optional macro SONAR_TIMEOUT_EN adds an echo wait/width timeout that reports 999 with erro=1.
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   medir      start request, accepted only while idle
//   echo       sensor echo, asynchronous to clock
//   trigger    sensor trigger pulse
//   medida     BCD distance [11:8] hundreds, [7:4] tens, [3:0] units
//   pronto     one-cycle pulse when medida is valid
//   erro       high while the last measurement timed out
//   db_estado  current state code for debug display
module sonar_medidor #(
  parameter int unsigned TRIGGER_CICLOS = 500,
  parameter int unsigned CICLOS_POR_CM  = 2941,
  parameter int unsigned TIMEOUT_CICLOS = 1250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        medir,
  input  logic        echo,
  output logic        trigger,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int unsigned CNT_MAX = (TRIGGER_CICLOS > TIMEOUT_CICLOS) ? TRIGGER_CICLOS : TIMEOUT_CICLOS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TICK_W  = $clog2(CICLOS_POR_CM + 1);
  localparam int unsigned BCD_W   = 12;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    GERA_TRIGGER = 4'h1,
    ESPERA_ECHO  = 4'h2,
    MEDE_ECHO    = 4'h3,
    ARMAZENA     = 4'h4,
    ERRO         = 4'hE,
    FINAL        = 4'hF
  } estado_t;

  estado_t             estado, estado_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [TICK_W-1:0]   tick, tick_d;
  logic [BCD_W-1:0]    acc, acc_d;
  logic [BCD_W-1:0]    medida_d;
  logic                trigger_d, pronto_d;
  logic [3:0]          db_estado_d;
  logic                eco_meta, eco_sinc;
  logic                conta_tick;
`ifdef SONAR_TIMEOUT_EN
  logic                erro_d;
`endif

  // Saturating BCD increment; 999 stays at 999.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [3:0] h, t, u;
    {h, t, u} = v;
    if (v == 12'h999) return v;
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  // Two-flop synchronizer for the asynchronous echo.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      eco_meta <= 1'b0;
      eco_sinc <= 1'b0;
    end else begin
      eco_meta <= echo;
      eco_sinc <= eco_meta;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= INICIAL;
      cnt       <= '0;
      tick      <= '0;
      acc       <= '0;
      medida    <= '0;
      trigger   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 4'h0;
`ifdef SONAR_TIMEOUT_EN
      erro      <= 1'b0;
`endif
    end else begin
      estado    <= estado_d;
      cnt       <= cnt_d;
      tick      <= tick_d;
      acc       <= acc_d;
      medida    <= medida_d;
      trigger   <= trigger_d;
      pronto    <= pronto_d;
      db_estado <= db_estado_d;
`ifdef SONAR_TIMEOUT_EN
      erro      <= erro_d;
`endif
    end
  end

`ifndef SONAR_TIMEOUT_EN
  assign erro = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    estado_d   = estado;
    cnt_d      = cnt;
    tick_d     = tick;
    acc_d      = acc;
    medida_d   = medida;
    conta_tick = 1'b0;
`ifdef SONAR_TIMEOUT_EN
    erro_d     = erro;
`endif

    case (estado)
      INICIAL: begin
        if (medir) begin
          estado_d = GERA_TRIGGER;
          cnt_d    = '0;
          tick_d   = '0;
          acc_d    = '0;
`ifdef SONAR_TIMEOUT_EN
          erro_d   = 1'b0;
`endif
        end
      end
      GERA_TRIGGER: begin
        if (cnt == CNT_W'(TRIGGER_CICLOS - 1)) begin
          estado_d = ESPERA_ECHO;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ESPERA_ECHO: begin
        // The first high cycle is part of the echo width, so it is counted here.
        if (eco_sinc) begin
          estado_d   = MEDE_ECHO;
          conta_tick = 1'b1;
          cnt_d      = '0;
        end
`ifdef SONAR_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
          estado_d = ERRO;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
`endif
      end
      MEDE_ECHO: begin
        if (!eco_sinc) begin
          estado_d = ARMAZENA;
        end else begin
          conta_tick = 1'b1;
`ifdef SONAR_TIMEOUT_EN
          if (cnt == CNT_W'(TIMEOUT_CICLOS - 1)) begin
            estado_d = ERRO;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
`endif
        end
      end
      ARMAZENA: begin
        medida_d = acc;
        estado_d = FINAL;
      end
      FINAL: begin
        estado_d = INICIAL;
      end
      ERRO: begin
`ifdef SONAR_TIMEOUT_EN
        medida_d = 12'h999;
        erro_d   = 1'b1;
        estado_d = FINAL;
`else
        estado_d = INICIAL;
`endif
      end
      default: begin
        estado_d = INICIAL;
      end
    endcase

    // One centimetre per CICLOS_POR_CM echo-high cycles.
    if (conta_tick) begin
      if (tick == TICK_W'(CICLOS_POR_CM - 1)) begin
        tick_d = '0;
        acc_d  = bcd_inc(acc);
      end else begin
        tick_d = tick + TICK_W'(1);
      end
    end

    trigger_d   = (estado_d == GERA_TRIGGER);
    pronto_d    = (estado_d == FINAL);
    db_estado_d = 4'(estado_d);
  end

endmodule
